// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
// March C- engine for a single-port memory with two-cycle read latency.
// Generates 10N operations (E0..E5), drives them through a short pipeline
// to the memory, and compares read data against the expected background.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a test (accepted in IDLE or DONE)
//   busy, done        run status; done held until next accepted start
//   fail, fail_count  any mismatch seen / saturating mismatch count
//   fail_addr         address of first mismatch
//   fail_element      March element (0..5) of first mismatch
//   mem_write_read    1 = write, 0 = read
//   mem_address       memory address
//   mem_wdata         write data, one cycle ahead of its op
//   mem_rdata         read data from memory
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            drain_q, drain_d;
    // generator
    logic                  gen_valid_q, gen_valid_d;
    logic [2:0]            gen_elem_q, gen_elem_d;
    logic                  gen_pair_q, gen_pair_d;
    logic [ADDR_WIDTH-1:0] gen_addr_q, gen_addr_d;
    // stage A
    logic                  a_valid_q, a_valid_d, a_write_q, a_write_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic [2:0]            a_elem_q, a_elem_d;
    logic [DATA_WIDTH-1:0] a_exp_q, a_exp_d, wdata_q, wdata_d;
    // stage B
    logic                  wr_q, wr_d, b_rd_q, b_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            b_elem_q, b_elem_d;
    logic [DATA_WIDTH-1:0] b_exp_q, b_exp_d;
    // compare delay (covers the memory's two-cycle read latency)
    logic                  c1_rd_q, c1_rd_d, c2_rd_q, c2_rd_d;
    logic [ADDR_WIDTH-1:0] c1_addr_q, c1_addr_d, c2_addr_q, c2_addr_d;
    logic [2:0]            c1_elem_q, c1_elem_d, c2_elem_q, c2_elem_d;
    logic [DATA_WIDTH-1:0] c1_exp_q, c1_exp_d, c2_exp_q, c2_exp_d;
    // results
    logic                  fail_q, fail_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [2:0]            felem_q, felem_d;

    // combinational decode of the generator's current op
    logic                  start_accept, gen_write, gen_paired, gen_down, gen_last_addr, gen_last_op;
    logic [2:0]            next_elem;
    logic [DATA_WIDTH-1:0] gen_data, gen_exp;

    always_comb begin
        start_accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
        gen_paired    = (gen_elem_q != 3'd0) && (gen_elem_q != 3'd5);
        gen_write     = (gen_elem_q == 3'd0) || (gen_paired && gen_pair_q);
        gen_down      = (gen_elem_q == 3'd3) || (gen_elem_q == 3'd4);
        gen_last_addr = gen_down ? (gen_addr_q == '0) : (gen_addr_q == ADDR_MAX);
        gen_last_op   = gen_valid_q && (gen_elem_q == 3'd5) && gen_last_addr;
        next_elem     = gen_elem_q + 3'd1;
        // odd elements write ones; E2/E4 read ones, the rest read zeros
        gen_data      = gen_elem_q[0] ? '1 : '0;
        gen_exp       = (gen_elem_q == 3'd2 || gen_elem_q == 3'd4) ? '1 : '0;
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        gen_valid_d = gen_valid_q;
        gen_elem_d  = gen_elem_q;
        gen_pair_d  = gen_pair_q;
        gen_addr_d  = gen_addr_q;
        fail_d      = fail_q;
        cnt_d       = cnt_q;
        faddr_d     = faddr_q;
        felem_d     = felem_q;

        case (state_q)
            ST_IDLE, ST_DONE: if (start_accept) state_d = ST_RUN;
            ST_RUN: if (gen_last_op) begin
                state_d = ST_DRAIN;
                drain_d = 2'd0;
            end
            ST_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd3) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_accept) begin
            gen_valid_d = 1'b1;
            gen_elem_d  = 3'd0;
            gen_pair_d  = 1'b0;
            gen_addr_d  = '0;
        end else if (gen_valid_q) begin
            if (gen_paired && !gen_pair_q) begin
                gen_pair_d = 1'b1;
            end else begin
                gen_pair_d = 1'b0;
                if (gen_last_addr) begin
                    if (gen_elem_q == 3'd5) begin
                        gen_valid_d = 1'b0;
                    end else begin
                        gen_elem_d = next_elem;
                        // down elements start at the top: E2->E3 stays on N-1
                        gen_addr_d = (next_elem == 3'd3 || next_elem == 3'd4) ? ADDR_MAX : '0;
                    end
                end else begin
                    gen_addr_d = gen_down ? gen_addr_q - 1'b1 : gen_addr_q + 1'b1;
                end
            end
        end

        // stage A: wdata only changes on writes so it leads its op cleanly
        a_valid_d = gen_valid_q;
        a_write_d = gen_write;
        a_addr_d  = gen_addr_q;
        a_elem_d  = gen_elem_q;
        a_exp_d   = gen_exp;
        wdata_d   = (gen_valid_q && gen_write) ? gen_data : wdata_q;

        // stage B: idle bus is a read of address 0
        wr_d     = a_valid_q && a_write_q;
        addr_d   = a_valid_q ? a_addr_q : '0;
        b_rd_d   = a_valid_q && !a_write_q;
        b_elem_d = a_elem_q;
        b_exp_d  = a_exp_q;

        c1_rd_d = b_rd_q;   c1_addr_d = addr_q;    c1_elem_d = b_elem_q;  c1_exp_d = b_exp_q;
        c2_rd_d = c1_rd_q;  c2_addr_d = c1_addr_q; c2_elem_d = c1_elem_q; c2_exp_d = c1_exp_q;

        if (start_accept) begin
            fail_d  = 1'b0;
            cnt_d   = '0;
            faddr_d = '0;
            felem_d = '0;
        end else if (c2_rd_q && (mem_rdata != c2_exp_q)) begin
            fail_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!fail_q) begin
                faddr_d = c2_addr_q;
                felem_d = c2_elem_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;     drain_q <= '0;
            gen_valid_q <= 1'b0;    gen_elem_q <= '0;  gen_pair_q <= 1'b0; gen_addr_q <= '0;
            a_valid_q <= 1'b0;      a_write_q <= 1'b0; a_addr_q <= '0;     a_elem_q <= '0;
            a_exp_q <= '0;          wdata_q <= '0;
            wr_q <= 1'b0;           addr_q <= '0;      b_rd_q <= 1'b0;     b_elem_q <= '0;  b_exp_q <= '0;
            c1_rd_q <= 1'b0;        c1_addr_q <= '0;   c1_elem_q <= '0;    c1_exp_q <= '0;
            c2_rd_q <= 1'b0;        c2_addr_q <= '0;   c2_elem_q <= '0;    c2_exp_q <= '0;
            fail_q <= 1'b0;         cnt_q <= '0;       faddr_q <= '0;      felem_q <= '0;
        end else begin
            state_q <= state_d;     drain_q <= drain_d;
            gen_valid_q <= gen_valid_d; gen_elem_q <= gen_elem_d; gen_pair_q <= gen_pair_d; gen_addr_q <= gen_addr_d;
            a_valid_q <= a_valid_d; a_write_q <= a_write_d; a_addr_q <= a_addr_d; a_elem_q <= a_elem_d;
            a_exp_q <= a_exp_d;     wdata_q <= wdata_d;
            wr_q <= wr_d;           addr_q <= addr_d;   b_rd_q <= b_rd_d;   b_elem_q <= b_elem_d; b_exp_q <= b_exp_d;
            c1_rd_q <= c1_rd_d;     c1_addr_q <= c1_addr_d; c1_elem_q <= c1_elem_d; c1_exp_q <= c1_exp_d;
            c2_rd_q <= c2_rd_d;     c2_addr_q <= c2_addr_d; c2_elem_q <= c2_elem_d; c2_exp_q <= c2_exp_d;
            fail_q <= fail_d;       cnt_q <= cnt_d;     faddr_q <= faddr_d; felem_q <= felem_d;
        end
    end

    assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign fail           = fail_q;
    assign fail_count     = cnt_q;
    assign fail_addr      = faddr_q;
    assign fail_element   = felem_q;
    assign mem_write_read = wr_q;
    assign mem_address    = addr_q;
    assign mem_wdata      = wdata_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 8;
    localparam int N  = 1 << AW;
    localparam int NOPS = 10 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, mem_write_read;
    logic [CW-1:0] fail_count;
    logic [AW-1:0] fail_addr, mem_address;
    logic [2:0]    fail_element;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fail(fail), .fail_count(fail_count), .fail_addr(fail_addr),
        .fail_element(fail_element), .mem_write_read(mem_write_read),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // memory under test: write uses wdata sampled one cycle earlier,
    // reads return two cycles later; one faulty address with stuck bits
    logic [DW-1:0] mem [N];
    logic [DW-1:0] wd_dly, rd1;
    int            flt_addr = 0;
    logic [DW-1:0] flt_sa1 = '0, flt_sa0 = '0;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;
        wd_dly = '0; rd1 = '0; mem_rdata = '0;
    end

    always @(posedge clk) begin
        wd_dly <= mem_wdata;
        if (mem_write_read) mem[mem_address] <= wd_dly;
        if (int'(mem_address) == flt_addr) rd1 <= (mem[mem_address] | flt_sa1) & ~flt_sa0;
        else                               rd1 <= mem[mem_address];
        mem_rdata <= rd1;
    end

    // reference model: March C- op list and expected results
    typedef struct {
        bit            wr;
        int            addr;
        logic [DW-1:0] data;
        int            elem;
    } op_t;
    op_t ops[$];
    int            m_fail, m_cnt, m_addr, m_elem;
    logic [DW-1:0] cur_wd = '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic build_model();
        logic [DW-1:0] mm [N];
        logic [DW-1:0] rd;
        op_t o;
        ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                o.addr = (e == 3 || e == 4) ? N - 1 - j : j;
                o.elem = e;
                if (e == 0 || e == 5) begin
                    o.wr = (e == 0); o.data = '0; ops.push_back(o);
                end else begin
                    o.wr = 0; o.data = (e == 2 || e == 4) ? '1 : '0; ops.push_back(o);
                    o.wr = 1; o.data = (e % 2 == 1) ? '1 : '0;       ops.push_back(o);
                end
            end
        end
        m_fail = 0; m_cnt = 0; m_addr = 0; m_elem = 0;
        for (int i = 0; i < N; i++) mm[i] = '0;
        foreach (ops[i]) begin
            if (ops[i].wr) mm[ops[i].addr] = ops[i].data;
            else begin
                rd = mm[ops[i].addr];
                if (ops[i].addr == flt_addr) rd = (rd | flt_sa1) & ~flt_sa0;
                if (rd != ops[i].data) begin
                    if (m_fail == 0) begin m_addr = ops[i].addr; m_elem = ops[i].elem; end
                    m_fail = 1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, fail, fail_count, fail_addr, fail_element,
                     mem_write_read, mem_address, mem_wdata}, 32'd0);
    endtask

    // one full run; cycle k = state after the k-th edge following the start edge
    task automatic run_test(input string tag, input bit hold_start, input int abort_at);
        logic [31:0] exp_vec;
        int          ew, ea;
        build_model();
        if (start == 1'b0) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " k0 status"}, {busy, done, fail, fail_count, fail_addr, fail_element, mem_wdata},
              {1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 3'd0, cur_wd});
        if (!hold_start) start = 1'b0;
        for (int k = 1; k <= NOPS + 4; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, " abort"});
                cur_wd = '0;
                return;
            end
            if (k - 1 < NOPS && ops[k-1].wr) cur_wd = ops[k-1].data;
            ew = 0; ea = 0;
            if (k >= 2 && k - 2 < NOPS) begin ew = ops[k-2].wr; ea = ops[k-2].addr; end
            exp_vec = {17'd0, (k <= NOPS + 3) ? 1'b1 : 1'b0, (k >= NOPS + 4) ? 1'b1 : 1'b0,
                       ew[0], ea[AW-1:0], cur_wd};
            check($sformatf("%s cycle %0d busy/done/bus", tag, k),
                  {17'd0, busy, done, mem_write_read, mem_address, mem_wdata}, exp_vec);
        end
        check({tag, " fail"},         {31'd0, fail}, m_fail);
        check({tag, " fail_count"},   {24'd0, fail_count}, m_cnt);
        check({tag, " fail_addr"},    {28'd0, fail_addr}, m_addr);
        check({tag, " fail_element"}, {29'd0, fail_element}, m_elem);
        $display("run %s: fail=%0d count=%0d addr=%0d elem=%0d", tag, fail, fail_count, fail_addr, fail_element);
    endtask

    task automatic set_fault(input int a, input logic [DW-1:0] s1, input logic [DW-1:0] s0);
        flt_addr = a; flt_sa1 = s1; flt_sa0 = s0;
    endtask

    initial begin
        #1;
        check_all_zero("reset values");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // fault-free, plus pins on the op sequence
        set_fault(0, '0, '0);
        build_model();
        check("model op total", ops.size(), 160);
        check("model op15 w0@15", {ops[15].wr, ops[15].addr[7:0], ops[15].data}, {1'b1, 8'd15, 8'h00});
        check("model op16 r0@0",  {ops[16].wr, ops[16].addr[7:0], ops[16].data}, {1'b0, 8'd0, 8'h00});
        check("model op17 w1@0",  {ops[17].wr, ops[17].addr[7:0], ops[17].data}, {1'b1, 8'd0, 8'hff});
        check("model op80 r0@15 E3", {ops[80].wr, ops[80].addr[7:0], ops[80].elem[7:0]}, {1'b0, 8'd15, 8'd3});
        run_test("clean", 0, 0);

        // bit 3 stuck-at-1 at address 5
        set_fault(5, 8'h08, 8'h00);
        build_model();
        check("model sa1 count", m_cnt, 3);
        check("model sa1 addr/elem", {m_addr[7:0], m_elem[7:0]}, {8'd5, 8'd1});
        run_test("sa1_b3_a5", 0, 0);

        // bit 0 stuck-at-0 at address 15
        set_fault(15, 8'h00, 8'h01);
        build_model();
        check("model sa0 count", m_cnt, 2);
        check("model sa0 addr/elem", {m_addr[7:0], m_elem[7:0]}, {8'd15, 8'd2});
        run_test("sa0_b0_a15", 0, 0);

        // randomized faults
        for (int r = 0; r < 4; r++) begin
            set_fault($urandom_range(0, N - 1), 8'(1 << $urandom_range(0, 7)),
                      ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            run_test($sformatf("rand%0d", r), 0, 0);
        end

        // abort mid-run, then a clean restart
        set_fault(3, 8'h10, 8'h00);
        run_test("abort", 0, 50);
        start = 1'b0;
        #3;
        check_all_zero("held in reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_fault(0, '0, '0);
        run_test("after_abort", 0, 0);

        // start held high: ignored while busy, re-accepted once done
        set_fault(5, 8'h08, 8'h00);
        run_test("held1", 1, 0);
        set_fault(0, '0, '0);
        run_test("held2", 1, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("done held", {30'd0, busy, done}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
